note_player: RTL and testbench

Tone source for the audio path. It produces signed 16-bit square-wave samples on both channels, and those samples feed the I2S speaker controller's `audio_in_left`/`audio_in_right` inputs. In manual mode it sounds the note selected by the switches. On a start pulse it plays a fixed 16-step melody from an internal ROM, then returns to manual mode.

---
 rtl/note_player_if.sv | 24 ++
 rtl/note_player.sv | 165 ++++++++++++++++
 tb/tb_note_player.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/note_player_if.sv
// Control and sample bus of the note_player tone source.
// The master drives the note/melody controls; the slave returns samples and status.
interface note_player_if;
  logic        start;
  logic        stop;
  logic [3:0]  note_sel;
  logic [1:0]  octave;
  logic [3:0]  volume;
  logic [15:0] audio_left;
  logic [15:0] audio_right;
  logic        busy;
  logic        done;
  logic [3:0]  step_idx;

  modport master (
    output start, stop, note_sel, octave, volume,
    input  audio_left, audio_right, busy, done, step_idx
  );

  modport slave (
    input  start, stop, note_sel, octave, volume,
    output audio_left, audio_right, busy, done, step_idx
  );
endinterface

// File: rtl/note_player.sv
// Square-wave tone source: manual note from the switches, or a 16-step melody from ROM.
// Produces identical signed 16-bit samples for the left and right speaker channels.
module note_player #(
  parameter int unsigned STEP_CYCLES = 4_000_000
) (
  input logic         clk,
  input logic         rst,
  note_player_if.slave bus
);

  typedef enum logic {IDLE, PLAY} state_t;

  localparam int unsigned       STEP_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

  state_t            state, state_d;
  logic [STEP_W-1:0] step_cnt;
  logic [3:0]        step_idx;
  logic              done_q;
  logic              step_end, melody_end, busy;

  logic [3:0]  tone_note;
  logic [1:0]  tone_oct;
  logic [5:0]  tone, prev_tone;
  logic [16:0] base, half;
  logic        silent;
  logic [16:0] phase_cnt, phase_cnt_d;
  logic        phase, phase_d;
  logic [15:0] amp, sample_d, audio;

  function automatic logic [5:0] melody_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    melody_rom = {4'd1,  2'd0};
      4'd1:    melody_rom = {4'd3,  2'd0};
      4'd2:    melody_rom = {4'd5,  2'd0};
      4'd3:    melody_rom = {4'd6,  2'd0};
      4'd4:    melody_rom = {4'd8,  2'd0};
      4'd5:    melody_rom = {4'd10, 2'd0};
      4'd6:    melody_rom = {4'd12, 2'd0};
      4'd7:    melody_rom = {4'd1,  2'd1};
      4'd8:    melody_rom = {4'd0,  2'd0};
      4'd9:    melody_rom = {4'd12, 2'd0};
      4'd10:   melody_rom = {4'd10, 2'd0};
      4'd11:   melody_rom = {4'd8,  2'd0};
      4'd12:   melody_rom = {4'd6,  2'd0};
      4'd13:   melody_rom = {4'd5,  2'd0};
      4'd14:   melody_rom = {4'd3,  2'd0};
      default: melody_rom = {4'd1,  2'd0};
    endcase
  endfunction

  // Half-period in clocks at octave 0; zero marks a silent note.
  function automatic logic [16:0] base_half(input logic [3:0] note);
    case (note)
      4'd1:    base_half = 17'd76445;
      4'd2:    base_half = 17'd72155;
      4'd3:    base_half = 17'd68105;
      4'd4:    base_half = 17'd64282;
      4'd5:    base_half = 17'd60675;
      4'd6:    base_half = 17'd57269;
      4'd7:    base_half = 17'd54055;
      4'd8:    base_half = 17'd51020;
      4'd9:    base_half = 17'd48158;
      4'd10:   base_half = 17'd45455;
      4'd11:   base_half = 17'd42903;
      4'd12:   base_half = 17'd40495;
      default: base_half = 17'd0;
    endcase
  endfunction

  assign step_end   = (step_cnt == STEP_LAST);
  assign melody_end = step_end && (step_idx == 4'd15);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (bus.start && !bus.stop)        state_d = PLAY;
      PLAY: if (bus.stop || melody_end)        state_d = IDLE;
      default:                                 state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == PLAY);
    tone_note = bus.note_sel;
    tone_oct  = bus.octave;
    if (state == PLAY) {tone_note, tone_oct} = melody_rom(step_idx);
  end

  // Step sequencing; step_idx wraps 15 -> 0 exactly when the melody ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= '0;
      step_idx <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        step_cnt <= '0;
        step_idx <= '0;
      end else if (bus.stop) begin
        step_cnt <= '0;
        step_idx <= '0;
      end else if (step_end) begin
        step_cnt <= '0;
        step_idx <= step_idx + 4'd1;
        done_q   <= melody_end;
      end else begin
        step_cnt <= step_cnt + STEP_W'(1);
      end
    end
  end

  assign tone   = {tone_note, tone_oct};
  assign base   = base_half(tone_note);
  assign half   = base >> tone_oct;
  assign silent = (base == 17'd0);
  assign amp    = {1'b0, bus.volume, 11'd0};

  // A tone change restarts the wave on a fresh positive half-period.
  always_comb begin
    phase_cnt_d = phase_cnt + 17'd1;
    phase_d     = phase;
    if (tone != prev_tone || silent) begin
      phase_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (phase_cnt == half - 17'd1) begin
      phase_cnt_d = '0;
      phase_d     = ~phase;
    end
  end

  always_comb begin
    sample_d = 16'd0;
    if (!silent) sample_d = phase_d ? amp : (16'd0 - amp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_tone <= '0;
      phase_cnt <= '0;
      phase     <= 1'b1;
      audio     <= '0;
    end else begin
      prev_tone <= tone;
      phase_cnt <= phase_cnt_d;
      phase     <= phase_d;
      audio     <= sample_d;
    end
  end

  assign bus.audio_left  = audio;
  assign bus.audio_right = audio;
  assign bus.busy        = busy;
  assign bus.done        = done_q;
  assign bus.step_idx    = step_idx;

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player: manual tones, melody timing, abort paths and async reset.
// Uses STEP_CYCLES=100 so full melodies stay short.
module tb_note_player;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  note_player_if bus ();

  note_player #(.STEP_CYCLES(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total   = 0;
  int bad     = 0;
  int lr_diff = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Waits (bounded) for the sample to reach val, then counts how long it holds.
  task automatic measure_run(input string tag, input logic [15:0] val, input int exp_len);
    int n;
    n = 0;
    while (bus.audio_left != val && n < 60000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, bus.audio_left, val);
    n = 0;
    while (bus.audio_left == val && n < 60000) begin
      if (bus.audio_right != bus.audio_left) lr_diff++;
      n++;
      @(negedge clk);
    end
    check({tag, "_len"}, n, exp_len);
  endtask

  function automatic logic [15:0] melody_exp(input int k);
    return (k == 8) ? 16'h0000 : 16'h2800;  // volume 5, phase 1 throughout each short step
  endfunction

  // Pulses start; t counts negedges after the sampling edge N (t=0 is cycle N+1).
  task automatic play_melody(input string tag, input bit extra_start);
    int done_cnt;
    done_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int t = 0; t <= 1605; t++) begin
      if (t == 0)    check({tag, "_busy_rise"}, bus.busy, 1'b1);
      if (t % 100 == 0 && t < 1600) check({tag, "_step"}, bus.step_idx, t / 100);
      if (t % 100 == 50) check({tag, "_audio"}, bus.audio_left, melody_exp(t / 100));
      if (t == 1599) check({tag, "_busy_last"}, bus.busy, 1'b1);
      if (t == 1600) begin
        check({tag, "_done"}, bus.done, 1'b1);
        check({tag, "_busy_fall"}, bus.busy, 1'b0);
        check({tag, "_step_end"}, bus.step_idx, 4'd0);
      end
      if (t == 1602) check({tag, "_manual_after"}, bus.audio_left, 16'h0000);
      if (bus.audio_right != bus.audio_left) lr_diff++;
      if (bus.done) done_cnt++;
      bus.start = (extra_start && t == 350);
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, "_done_count"}, done_cnt, 1);
  endtask

  initial begin
    int n;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.note_sel = 4'd0;
    bus.octave   = 2'd0;
    bus.volume   = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_audio", bus.audio_left, 16'h0000);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_step", bus.step_idx, 4'd0);
    rst = 1'b0;

    // Manual A4 at full volume.
    bus.note_sel = 4'd10;
    bus.octave   = 2'd0;
    bus.volume   = 4'd15;
    measure_run("a4_pos", 16'h7800, 45455);
    check("a4_neg", bus.audio_left, 16'h8800);

    // Three octaves up, minimum volume.
    bus.octave = 2'd3;
    bus.volume = 4'd1;
    measure_run("o3_pos", 16'h0800, 5681);
    measure_run("o3_neg", 16'hF800, 5681);
    check("o3_wrap", bus.audio_left, 16'h0800);

    bus.volume = 4'd0;
    @(negedge clk);
    n = 0;
    repeat (200) begin
      if (bus.audio_left != 16'h0000 || bus.audio_right != 16'h0000) n++;
      @(negedge clk);
    end
    check("vol0_quiet", n, 0);

    // Silent notes.
    bus.volume   = 4'd15;
    bus.note_sel = 4'd0;
    bus.octave   = 2'd0;
    @(negedge clk);
    n = 0;
    repeat (200) begin
      if (bus.audio_left != 16'h0000) n++;
      @(negedge clk);
    end
    check("note0_quiet", n, 0);
    bus.note_sel = 4'd14;
    @(negedge clk);
    n = 0;
    repeat (200) begin
      if (bus.audio_left != 16'h0000) n++;
      @(negedge clk);
    end
    check("note14_quiet", n, 0);

    // Full melody, manual tone silent so the return to manual is visible.
    bus.note_sel = 4'd0;
    bus.volume   = 4'd5;
    play_melody("mel", 1'b0);
    play_melody("mel2", 1'b1);

    // Stop during step 5.
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (550) @(negedge clk);
    check("stop_pre_step", bus.step_idx, 4'd5);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check("stop_busy", bus.busy, 1'b0);
    check("stop_step", bus.step_idx, 4'd0);
    check("stop_audio_rom", bus.audio_left, 16'h2800);
    @(negedge clk);
    check("stop_audio_manual", bus.audio_left, 16'h0000);
    n = 0;
    repeat (1700) begin
      if (bus.done || bus.busy) n++;
      @(negedge clk);
    end
    check("stop_no_done", n, 0);

    // start and stop together while idle.
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("both_busy", bus.busy, 1'b0);
    repeat (5) @(negedge clk);
    check("both_busy_later", bus.busy, 1'b0);
    check("both_step", bus.step_idx, 4'd0);

    // Async reset in the middle of step 3.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (350) @(negedge clk);
    check("rst_pre_step", bus.step_idx, 4'd3);
    check("rst_pre_audio", bus.audio_left, 16'h2800);
    #2 rst = 1'b1;
    #1;
    check("arst_audio", bus.audio_left, 16'h0000);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_step", bus.step_idx, 4'd0);
    check("arst_done", bus.done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    play_melody("replay", 1'b0);

    check("lr_match", lr_diff, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
